// File: rtl/stage_mem.sv
// stage_mem: br32 memory stage; passes ALU results through, runs single-beat load/store bus transactions, registers writeback
// Ports: clk, rst_n (synchronous, active-low); ex_* instruction from execute; stall holds upstream;
//        bus_* single-beat request/ack data bus; wb_* registered writeback bundle (wb_fault = misaligned or timed out)
module stage_mem #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_mem_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_w_rd,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [1:0]  ex_size,
    input  logic        ex_signed,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_w_rd,
    output logic [31:0] wb_data,
    output logic        wb_fault
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt, cnt_cur;
    logic          s_bubble, s_w_rd, s_load, s_store, s_signed;
    logic [31:0]   s_alu, s_data;
    logic [4:0]    s_rd;
    logic [1:0]    s_size;
    logic          mem_op, is_store, misaligned, timed_out, retire, wb_go, fault;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   ld_data;

    always_comb begin
        mem_op     = !s_bubble && (s_load || s_store);
        is_store   = s_store && !s_load;
        misaligned = (s_size == 2'd1) ? s_alu[0] : (s_size[1] && s_alu[1:0] != 2'b00);
        bus_req    = mem_op && !misaligned;
        cnt_cur    = (state == S_IDLE) ? '0 : cnt;
        // an ack in the last allowed cycle beats the timeout
        timed_out  = bus_req && !bus_ack && cnt_cur == CW'(TIMEOUT - 1);
        retire     = !mem_op || misaligned || (bus_req && bus_ack) || timed_out;
        wb_go      = retire && !s_bubble;
        stall      = mem_op && !retire;
        fault      = mem_op && (misaligned || timed_out);
        bus_we     = bus_req && is_store;
        bus_addr   = bus_req ? {s_alu[31:2], 2'b00} : '0;
        bus_be     = !bus_req ? 4'b0000 :
                     (s_size == 2'd0) ? 4'b0001 << s_alu[1:0] :
                     (s_size == 2'd1) ? (s_alu[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        bus_wdata  = !bus_req ? '0 :
                     (s_size == 2'd0) ? {4{s_data[7:0]}} :
                     (s_size == 2'd1) ? {2{s_data[15:0]}} : s_data;
        lane_b     = 8'(bus_rdata >> {s_alu[1:0], 3'b000});
        lane_h     = 16'(bus_rdata >> {s_alu[1], 4'b0000});
        ld_data    = (s_size == 2'd0) ? {{24{s_signed && lane_b[7]}}, lane_b} :
                     (s_size == 2'd1) ? {{16{s_signed && lane_h[15]}}, lane_h} : bus_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            s_bubble <= 1'b1;
            s_alu    <= '0;
            s_data   <= '0;
            s_rd     <= '0;
            s_w_rd   <= 1'b0;
            s_load   <= 1'b0;
            s_store  <= 1'b0;
            s_size   <= '0;
            s_signed <= 1'b0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_w_rd  <= 1'b0;
            wb_data  <= '0;
            wb_fault <= 1'b0;
        end else begin
            // stall only ever holds an issued, unfinished request
            state <= stall ? S_WAIT : S_IDLE;
            cnt   <= stall ? cnt_cur + CW'(1) : '0;
            if (!stall) begin
                s_bubble <= !ex_valid;
                s_alu    <= ex_alu_res;
                s_data   <= ex_mem_data;
                s_rd     <= ex_rd;
                s_w_rd   <= ex_w_rd;
                s_load   <= ex_load;
                s_store  <= ex_store;
                s_size   <= ex_size;
                s_signed <= ex_signed;
            end
            wb_valid <= wb_go;
            wb_rd    <= wb_go ? s_rd : '0;
            wb_w_rd  <= wb_go && s_w_rd && !fault && !(mem_op && is_store);
            wb_data  <= (!wb_go || fault) ? '0 : !mem_op ? s_alu : is_store ? '0 : ld_data;
            wb_fault <= wb_go && fault;
        end
    end
endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: directed vector table plus multi-cycle sequences for stage_mem
module tb_stage_mem;
    logic        clk, rst_n;
    logic        ex_valid, ex_w_rd, ex_load, ex_store, ex_signed;
    logic [31:0] ex_alu_res, ex_mem_data;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_size;
    logic        stall, bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        wb_valid, wb_w_rd, wb_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    int          checks = 0;
    int          errors = 0;

    stage_mem #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_alu_res(ex_alu_res), .ex_mem_data(ex_mem_data),
        .ex_rd(ex_rd), .ex_w_rd(ex_w_rd), .ex_load(ex_load), .ex_store(ex_store),
        .ex_size(ex_size), .ex_signed(ex_signed),
        .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_w_rd(wb_w_rd), .wb_data(wb_data),
        .wb_fault(wb_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        v;
        logic [31:0] alu;
        logic [31:0] md;
        logic [4:0]  rd;
        logic        wrd, ld, st;
        logic [1:0]  sz;
        logic        sg, ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_wv;
        logic [4:0]  e_rd;
        logic        e_wwrd;
        logic [31:0] e_wd;
        logic        e_wf;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] md, input logic [4:0] rd,
                         input logic wrd, input logic ld, input logic st, input logic [1:0] sz, input logic sg);
        ex_valid = v; ex_alu_res = alu; ex_mem_data = md; ex_rd = rd;
        ex_w_rd = wrd; ex_load = ld; ex_store = st; ex_size = sz; ex_signed = sg;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " stall"}, stall, 0);
        chk({tag, " bus_req"}, bus_req, 0);
        chk({tag, " bus_we"}, bus_we, 0);
        chk({tag, " bus_addr"}, bus_addr, 0);
        chk({tag, " bus_wdata"}, bus_wdata, 0);
        chk({tag, " bus_be"}, bus_be, 0);
        chk({tag, " wb_valid"}, wb_valid, 0);
        chk({tag, " wb_rd"}, wb_rd, 0);
        chk({tag, " wb_w_rd"}, wb_w_rd, 0);
        chk({tag, " wb_data"}, wb_data, 0);
        chk({tag, " wb_fault"}, wb_fault, 0);
    endtask

    task automatic run_vec(input int i, input vec_t t);
        string tag;
        tag = $sformatf("vec%0d", i);
        drive(t.v, t.alu, t.md, t.rd, t.wrd, t.ld, t.st, t.sz, t.sg);
        tick();
        ex_valid = 0; ex_load = 0; ex_store = 0;
        bus_ack = t.ack; bus_rdata = t.rdata;
        #3;
        chk({tag, " stall"}, stall, 0);
        chk({tag, " bus_req"}, bus_req, t.e_req);
        if (t.e_req) begin
            chk({tag, " bus_addr"}, bus_addr, t.e_addr);
            chk({tag, " bus_we"}, bus_we, t.e_we);
        end
        if (t.e_we) begin
            chk({tag, " bus_be"}, bus_be, t.e_be);
            chk({tag, " bus_wdata"}, bus_wdata, t.e_wdata);
        end
        tick();
        bus_ack = 0;
        chk({tag, " wb_valid"}, wb_valid, t.e_wv);
        chk({tag, " wb_w_rd"}, wb_w_rd, t.e_wwrd);
        chk({tag, " wb_fault"}, wb_fault, t.e_wf);
        if (t.e_wv) chk({tag, " wb_rd"}, wb_rd, t.e_rd);
        if (t.e_wv && !t.e_wf) chk({tag, " wb_data"}, wb_data, t.e_wd);
    endtask

    initial begin
        int n;
        logic got;
        // v alu md rd wrd ld st sz sg ack rdata | req addr we be wdata | wv rd wwrd wd wf
        vecs[0]  = '{1, 32'h1234, 0, 5'd5, 1, 0, 0, 2'd2, 0, 0, 0,            0, 0, 0, 0, 0,                          1, 5'd5,  1, 32'h1234, 0};
        vecs[1]  = '{1, 32'h1003, 0, 5'd7, 1, 1, 0, 2'd0, 1, 1, 32'h80AABBCC, 1, 32'h1000, 0, 0, 0,                 1, 5'd7,  1, 32'hFFFFFF80, 0};
        vecs[2]  = '{1, 32'h1001, 0, 5'd8, 1, 1, 0, 2'd0, 0, 1, 32'h80AABBCC, 1, 32'h1000, 0, 0, 0,                 1, 5'd8,  1, 32'h000000BB, 0};
        vecs[3]  = '{1, 32'h2000, 0, 5'd9, 1, 1, 0, 2'd1, 1, 1, 32'h1234F00D, 1, 32'h2000, 0, 0, 0,                 1, 5'd9,  1, 32'hFFFFF00D, 0};
        vecs[4]  = '{1, 32'h2002, 0, 5'd10, 1, 1, 0, 2'd1, 0, 1, 32'h1234F00D, 1, 32'h2000, 0, 0, 0,                1, 5'd10, 1, 32'h00001234, 0};
        vecs[5]  = '{1, 32'h0040, 0, 5'd11, 1, 1, 0, 2'd2, 0, 1, 32'hDEADBEEF, 1, 32'h0040, 0, 0, 0,                1, 5'd11, 1, 32'hDEADBEEF, 0};
        vecs[6]  = '{1, 32'h0101, 32'h12345655, 5'd12, 1, 0, 1, 2'd0, 0, 1, 0, 1, 32'h0100, 1, 4'b0010, 32'h55555555, 1, 5'd12, 0, 32'h0, 0};
        vecs[7]  = '{1, 32'h0204, 32'hCAFEBABE, 5'd0, 0, 0, 1, 2'd3, 0, 1, 0,  1, 32'h0204, 1, 4'b1111, 32'hCAFEBABE, 1, 5'd0,  0, 32'h0, 0};
        vecs[8]  = '{1, 32'h3001, 0, 5'd13, 1, 1, 0, 2'd2, 0, 0, 0,            0, 0, 0, 0, 0,                          1, 5'd13, 0, 32'h0, 1};
        vecs[9]  = '{1, 32'h3003, 32'h1111, 5'd14, 1, 0, 1, 2'd1, 0, 0, 0,     0, 0, 0, 0, 0,                          1, 5'd14, 0, 32'h0, 1};
        vecs[10] = '{0, 32'h0050, 0, 5'd15, 1, 1, 0, 2'd2, 0, 0, 0,            0, 0, 0, 0, 0,                          0, 5'd0,  0, 32'h0, 0};
        vecs[11] = '{1, 32'h0044, 32'h9, 5'd15, 1, 1, 1, 2'd2, 0, 1, 32'hCAFEF00D, 1, 32'h0044, 0, 0, 0,            1, 5'd15, 1, 32'hCAFEF00D, 0};
        vecs[12] = '{1, 32'hABCD, 0, 5'd16, 0, 0, 0, 2'd0, 0, 0, 0,            0, 0, 0, 0, 0,                          1, 5'd16, 0, 32'hABCD, 0};
        vecs[13] = '{1, 32'h1002, 0, 5'd17, 1, 1, 0, 2'd0, 1, 1, 32'h80AABBCC, 1, 32'h1000, 0, 0, 0,                1, 5'd17, 1, 32'hFFFFFFAA, 0};

        rst_n = 0; bus_ack = 0; bus_rdata = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk_zero("reset");
        rst_n = 1;
        tick();

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // half store, ack after three wait cycles, next ALU op queued behind it
        drive(1, 32'h2002, 32'h0000BEEF, 5'd3, 1, 0, 1, 2'd1, 0);
        tick();
        drive(1, 32'h99, 0, 5'd9, 1, 0, 0, 2'd0, 0);
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("hs stall", stall, 1);
            chk("hs bus_req", bus_req, 1);
            chk("hs bus_addr", bus_addr, 32'h2000);
            chk("hs bus_we", bus_we, 1);
            chk("hs bus_be", bus_be, 4'b1100);
            chk("hs bus_wdata", bus_wdata, 32'hBEEFBEEF);
            chk("hs wb_valid", wb_valid, 0);
            tick();
        end
        bus_ack = 1;
        #3;
        chk("hs ack stall", stall, 0);
        tick();
        bus_ack = 0; ex_valid = 0;
        chk("hs wb_valid", wb_valid, 1);
        chk("hs wb_rd", wb_rd, 3);
        chk("hs wb_w_rd", wb_w_rd, 0);
        chk("hs wb_fault", wb_fault, 0);
        tick();
        chk("hs next wb_valid", wb_valid, 1);
        chk("hs next wb_data", wb_data, 32'h99);
        chk("hs next wb_rd", wb_rd, 9);

        // timeout with TIMEOUT=4
        drive(1, 32'h500, 0, 5'd4, 1, 1, 0, 2'd2, 0);
        tick();
        drive(1, 32'h77, 0, 5'd6, 1, 0, 0, 2'd0, 0);
        n = 0; got = 0;
        for (int i = 0; i < 20; i++) begin
            #3;
            if (bus_req) n++;
            tick();
            if (wb_valid) begin
                got = 1;
                break;
            end
        end
        chk("to retired", got, 1);
        chk("to req cycles", n, 4);
        chk("to wb_fault", wb_fault, 1);
        chk("to wb_w_rd", wb_w_rd, 0);
        ex_valid = 0;
        tick();
        chk("to next wb_valid", wb_valid, 1);
        chk("to next wb_data", wb_data, 32'h77);
        chk("to next wb_fault", wb_fault, 0);

        // reset during the second wait cycle, late ack ignored
        drive(1, 32'h600, 0, 5'd2, 1, 1, 0, 2'd2, 0);
        tick();
        ex_valid = 0; ex_load = 0;
        #3;
        chk("rw stall", stall, 1);
        chk("rw bus_req", bus_req, 1);
        tick();
        rst_n = 0;
        tick();
        chk_zero("rw reset");
        rst_n = 1; bus_ack = 1; bus_rdata = 32'h123;
        #3;
        chk("rw late bus_req", bus_req, 0);
        chk("rw late stall", stall, 0);
        tick();
        bus_ack = 0;
        chk("rw late wb_valid", wb_valid, 0);
        chk("rw late wb_w_rd", wb_w_rd, 0);
        tick();
        chk("rw idle wb_valid", wb_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stage_mem.md
# stage_mem

Memory stage of the br32 pipeline, the consumer of the execute stage's outputs. It holds one instruction per cycle. Non-memory instructions pass straight through to writeback. Loads and stores run a single-beat request/acknowledge transaction on the data bus, and the stage stalls the upstream pipeline until the transaction completes, faults or times out. Results go out as a registered writeback bundle.

## Interface
- TIMEOUT, 255: consecutive unacknowledged request cycles before a bus fault (≥1)
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- ex_valid  in  1  execute slot holds a real instruction (not a bubble)
- ex_alu_res  in  32  ALU result or effective address
- ex_mem_data  in  32  store data
- ex_rd  in  5  destination register
- ex_w_rd  in  1  instruction writes rd
- ex_load, ex_store  in  1 each  memory op type; ex_load wins if both are set
- ex_size  in  2  0 byte, 1 half, 2/3 word
- ex_signed  in  1  sign-extend load
- stall  out  1  upstream must hold its outputs this cycle
- bus_req  out  1  request valid
- bus_we  out  1  write
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_ack  in  1  completion, single-cycle pulse
- bus_rdata  in  32  read data, valid with bus_ack
- wb_valid  out  1  writeback slot holds a retired instruction
- wb_rd  out  5  destination register
- wb_w_rd  out  1  register write enable
- wb_data  out  32  result
- wb_fault  out  1  op retired with misalignment or timeout

## Operation
- Capture: at each posedge with stall=0, latch all ex_* into the stage registers. The stage bubble bit takes !ex_valid || !rst_n. With stall=1, the stage registers hold.
- A held instruction is a mem op when it is not a bubble and ex_load or ex_store is set.
- Alignment: a half access with addr[0]=1 is misaligned. A word access with addr[1:0]≠0 is misaligned.
  - A misaligned op never asserts bus_req.
  - It retires at the next edge with wb_fault=1 and wb_w_rd=0.
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT: request issued, no ack yet.
- Transitions:
  - An aligned mem op held in IDLE asserts bus_req combinationally in that same cycle.
  - bus_ack in that cycle: retire, stay IDLE.
  - No ack: go to WAIT.
  - In WAIT, bus_req stays high and addr/we/wdata/be stay stable.
  - In WAIT, ack: retire and go to IDLE.
  - In WAIT, timeout: retire with fault and go to IDLE.
- Timeout: a counter clears in IDLE and increments each request cycle without ack. The op faults on the TIMEOUT-th consecutive unacked request cycle. An ack in that same cycle takes priority over the timeout.
- Stall rule: stall = held mem op && !(retiring this cycle). Non-mem ops and bubbles never stall.
- Store byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Store write data:
  - byte: {4{d[7:0]}}
  - half: {2{d[15:0]}}
  - word: d
- Load data: select the byte or half lane by the address bits, then zero- or sign-extend per ex_signed.
- Writeback register, updated every edge:
  - wb_valid = retiring, non-bubble.
  - wb_data is alu_res for non-mem ops, extracted load data for loads, 0 for stores.
  - wb_w_rd = w_rd && !fault && !store.
  - Nothing retires while stall=1. During a stall, wb_valid=0 and wb_w_rd=0.
- bus_ack arriving in IDLE with no request is ignored.

## Timing
- Reset (edge with rst_n=0):
  - FSM goes to IDLE, counter 0, stage bubble=1.
  - All outputs read 0 after the edge: stall, bus_req, bus_we, bus_addr, bus_wdata, bus_be, wb_valid, wb_rd, wb_w_rd, wb_data, wb_fault.
- Non-mem op captured at edge N appears on wb_* after edge N+1.
- Mem op captured at edge N with ack k cycles later (k≥0) appears on wb_* after edge N+1+k. stall is high for exactly k cycles.
- Reset mid-WAIT: bus_req drops after the reset edge, the op is discarded with no writeback, and a later ack is ignored.
- A timeout with TIMEOUT=T gives T cycles of bus_req, then wb_fault=1 for one cycle.

## Test plan
- ALU passthrough:
  - Stimulus: ex_valid=1, alu_res=0x1234, rd=5, w_rd=1.
  - Required: next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, stall never asserted.
- Zero-wait signed byte load:
  - Stimulus: addr 0x1003, rdata=0x80AABBCC, ack in the same cycle.
  - Required: bus_addr=0x1000, wb_data=0xFFFFFF80, no stall.
- Half store with wait:
  - Stimulus: addr 0x2002, data 0xBEEF, ack after 3 cycles.
  - Required: be=1100, wdata=0xBEEFBEEF, stall high for 3 cycles, wb_w_rd=0.
- Misaligned word load:
  - Stimulus: addr 0x3001.
  - Required: no bus_req, wb_fault=1, wb_w_rd=0.
- Timeout:
  - Stimulus: TIMEOUT=4, load with no ack.
  - Required: bus_req high for exactly 4 cycles, then wb_fault=1; the next instruction proceeds.
- Reset mid-WAIT:
  - Stimulus: rst_n=0 during cycle 2 of a wait, ack arrives afterwards.
  - Required: all outputs 0 after the edge; the ack causes no writeback.
